ai_shot_ctrl: RTL and testbench

Sequencer wrapped around the horizontal ship-placement density engine. On a shot request it latches the board state (fired map, live-ship mask) and drives it to the engine. It launches one density pass and waits for completion, then scans all 100 cells for the highest-density unfired cell. The result is returned as the AI's next shot over a valid/ready handshake to the game FSM.

---
 rtl/ai_shot_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ai_shot_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_shot_ctrl.sv
//==============================================================================
// Module  : ai_shot_ctrl
// Brief   : Shot sequencer around the ship-placement density engine; picks the
//           highest-density unfired cell and returns it over valid/ready.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ai_shot_ctrl #(
  parameter int CELLS   = 100,
  parameter int DW      = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CELLS-1:0]    fired,
  input  logic [4:0]          ships,
  output logic [CELLS-1:0]    eng_fired,
  output logic [4:0]          eng_ships,
  output logic                eng_start,
  input  logic                eng_done,
  input  logic [CELLS*DW-1:0] density,
  output logic                shot_valid,
  input  logic                shot_ready,
  output logic [6:0]          shot_pos,
  output logic [3:0]          shot_row,
  output logic [3:0]          shot_col,
  output logic [DW-1:0]       shot_density,
  output logic                no_target,
  output logic                timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_SCAN   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [TW-1:0]   r_tmo;
  logic            r_fb;
  logic [6:0]      r_idx;
  logic [3:0]      r_row;
  logic [3:0]      r_col;
  logic            r_have;
  logic [6:0]      r_best_pos;
  logic [3:0]      r_best_row;
  logic [3:0]      r_best_col;
  logic [DW-1:0]   r_best_d;

  logic [DW-1:0]   w_dens_arr [CELLS];
  logic [DW-1:0]   w_dens;
  logic            w_take;
  logic            w_tmo_hit;
  logic            w_last;

  generate
    for (genvar g = 0; g < CELLS; g++) begin : g_dens
      assign w_dens_arr[g] = density[g*DW +: DW];
    end
  endgenerate

  // Fallback mode after an engine timeout treats every cell as density 0.
  assign w_dens    = r_fb ? '0 : w_dens_arr[r_idx];
  assign w_take    = !eng_fired[r_idx] && (!r_have || (w_dens > r_best_d));
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
  assign w_last    = (r_idx == 7'(CELLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    eng_start  = 1'b0;
    shot_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (ships == 5'd0) ? S_OUT : S_LAUNCH;
      end
      S_LAUNCH: begin
        eng_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done || w_tmo_hit) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (w_last) w_next = S_OUT;
      end
      S_OUT: begin
        shot_valid = 1'b1;
        if (shot_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_fired    <= '0;
      eng_ships    <= '0;
      shot_pos     <= '0;
      shot_row     <= '0;
      shot_col     <= '0;
      shot_density <= '0;
      no_target    <= 1'b0;
      timeout_err  <= 1'b0;
      r_tmo        <= '0;
      r_fb         <= 1'b0;
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_have       <= 1'b0;
      r_best_pos   <= '0;
      r_best_row   <= '0;
      r_best_col   <= '0;
      r_best_d     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            eng_fired <= fired;
            eng_ships <= ships;
            if (ships == 5'd0) begin
              shot_pos     <= 7'd127;
              shot_row     <= 4'd15;
              shot_col     <= 4'd15;
              shot_density <= '0;
              no_target    <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_tmo      <= '0;
          r_fb       <= 1'b0;
          r_idx      <= '0;
          r_row      <= '0;
          r_col      <= '0;
          r_have     <= 1'b0;
          r_best_pos <= '0;
          r_best_row <= '0;
          r_best_col <= '0;
          r_best_d   <= '0;
        end
        S_WAIT: begin
          if (!eng_done) begin
            if (w_tmo_hit) begin
              timeout_err <= 1'b1;
              r_fb        <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
        end
        S_SCAN: begin
          if (w_take) begin
            r_have     <= 1'b1;
            r_best_pos <= r_idx;
            r_best_row <= r_row;
            r_best_col <= r_col;
            r_best_d   <= w_dens;
          end
          if (r_col == 4'd9) begin
            r_col <= '0;
            r_row <= r_row + 4'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
          if (!w_last) r_idx <= r_idx + 7'd1;
          // Final cell is folded in combinationally so the result lands with OUT.
          if (w_last) begin
            if (w_take) begin
              shot_pos     <= r_idx;
              shot_row     <= r_row;
              shot_col     <= r_col;
              shot_density <= w_dens;
              no_target    <= 1'b0;
            end else if (r_have) begin
              shot_pos     <= r_best_pos;
              shot_row     <= r_best_row;
              shot_col     <= r_best_col;
              shot_density <= r_best_d;
              no_target    <= 1'b0;
            end else begin
              shot_pos     <= 7'd127;
              shot_row     <= 4'd15;
              shot_col     <= 4'd15;
              shot_density <= '0;
              no_target    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ai_shot_ctrl.sv
//==============================================================================
// Module  : tb_ai_shot_ctrl
// Brief   : Directed self-checking bench for ai_shot_ctrl.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_ai_shot_ctrl;

  localparam int CELLS   = 100;
  localparam int DW      = 6;
  localparam int TIMEOUT = 1023;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic [CELLS-1:0]    fired;
  logic [4:0]          ships;
  logic [CELLS-1:0]    eng_fired;
  logic [4:0]          eng_ships;
  logic                eng_start;
  logic                eng_done;
  logic [CELLS*DW-1:0] density;
  logic                shot_valid;
  logic                shot_ready;
  logic [6:0]          shot_pos;
  logic [3:0]          shot_row;
  logic [3:0]          shot_col;
  logic [DW-1:0]       shot_density;
  logic                no_target;
  logic                timeout_err;

  int total = 0;
  int bad   = 0;

  ai_shot_ctrl #(.CELLS(CELLS), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .fired(fired), .ships(ships),
    .eng_fired(eng_fired), .eng_ships(eng_ships),
    .eng_start(eng_start), .eng_done(eng_done), .density(density),
    .shot_valid(shot_valid), .shot_ready(shot_ready),
    .shot_pos(shot_pos), .shot_row(shot_row), .shot_col(shot_col),
    .shot_density(shot_density), .no_target(no_target),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mod(input int m);
    for (int i = 0; i < CELLS; i++) density[i*DW +: DW] = DW'(i % m);
  endtask

  task automatic set_d(input int i, input int v);
    density[i*DW +: DW] = DW'(v);
  endtask

  task automatic accept(input logic [CELLS-1:0] f, input logic [4:0] s);
    fired     = f;
    ships     = s;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Called right after accept: done is sampled on the 5th edge after accept.
  task automatic done_at5;
    tick(); tick(); tick(); tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (shot_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (shot_valid) ok = 1'b1;
  endtask

  task automatic handshake;
    shot_ready = 1'b1;
    tick();
    shot_ready = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({req_ready, eng_start, shot_valid, shot_pos, shot_row, shot_col, shot_density, no_target, timeout_err}
        !== {1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b st=%b v=%b pos=%0d r=%0d c=%0d d=%0d nt=%b te=%b, want rdy=1 others 0",
               req_ready, eng_start, shot_valid, shot_pos, shot_row, shot_col, shot_density, no_target, timeout_err);
    end
    total++;
    if ({eng_fired, eng_ships} !== '0) begin
      bad++;
      $display("FAIL reset_eng_latch: got fired=%h ships=%b, want 0", eng_fired, eng_ships);
    end
  endtask

  task automatic test_peak;
    fill_mod(16);
    set_d(44, 20);
    accept('0, 5'b11111);
    total++;
    if (eng_start !== 1'b1) begin
      bad++; $display("FAIL peak_start_pulse: got %b want 1", eng_start);
    end
    total++;
    if ({eng_fired, eng_ships} !== {100'd0, 5'b11111}) begin
      bad++; $display("FAIL peak_latch: got ships=%b want 11111", eng_ships);
    end
    tick();
    total++;
    if (eng_start !== 1'b0) begin
      bad++; $display("FAIL peak_start_single: got %b want 0", eng_start);
    end
    tick(); tick(); tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    total++;
    if (shot_valid !== 1'b0) begin
      bad++; $display("FAIL peak_valid_early: got %b want 0 at D+100", shot_valid);
    end
    tick();
    total++;
    if (shot_valid !== 1'b1) begin
      bad++; $display("FAIL peak_valid_time: got %b want 1 at D+101", shot_valid);
    end
    total++;
    if ({shot_pos, shot_row, shot_col, shot_density, no_target} !== {7'd44, 4'd4, 4'd4, 6'd20, 1'b0}) begin
      bad++;
      $display("FAIL peak_result: got pos=%0d r=%0d c=%0d d=%0d nt=%b want 44 4 4 20 0",
               shot_pos, shot_row, shot_col, shot_density, no_target);
    end
    handshake();
    total++;
    if ({shot_valid, req_ready} !== 2'b01) begin
      bad++; $display("FAIL peak_handshake: got v=%b rdy=%b want v=0 rdy=1", shot_valid, req_ready);
    end
  endtask

  // Issued right after the previous handshake: earliest legal accept.
  task automatic test_back_to_back_tie;
    bit ok;
    fill_mod(1);
    set_d(12, 9);
    set_d(37, 9);
    accept('0, 5'b00111);
    done_at5();
    wait_valid(200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL tie_timeout: got no shot_valid want valid");
    end
    total++;
    if ({shot_pos, shot_row, shot_col, shot_density, no_target} !== {7'd12, 4'd1, 4'd2, 6'd9, 1'b0}) begin
      bad++;
      $display("FAIL tie_result: got pos=%0d r=%0d c=%0d d=%0d want 12 1 2 9",
               shot_pos, shot_row, shot_col, shot_density);
    end
    handshake();
  endtask

  task automatic test_fired_skip;
    bit ok;
    logic [CELLS-1:0] f;
    f = '0;
    f[44] = 1'b1;
    fill_mod(8);
    set_d(44, 30);
    set_d(71, 8);
    tick();
    accept(f, 5'b10101);
    done_at5();
    wait_valid(200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL skip_timeout: got no shot_valid want valid");
    end
    total++;
    if ({shot_pos, shot_row, shot_col, shot_density, no_target} !== {7'd71, 4'd7, 4'd1, 6'd8, 1'b0}) begin
      bad++;
      $display("FAIL skip_result: got pos=%0d r=%0d c=%0d d=%0d want 71 7 1 8",
               shot_pos, shot_row, shot_col, shot_density);
    end
    handshake();
  endtask

  task automatic test_all_fired;
    bit ok;
    fill_mod(50);
    tick();
    accept('1, 5'b00001);
    total++;
    if (eng_start !== 1'b1) begin
      bad++; $display("FAIL allfired_start: got %b want 1", eng_start);
    end
    done_at5();
    wait_valid(200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL allfired_timeout: got no shot_valid want valid");
    end
    total++;
    if ({shot_pos, shot_row, shot_col, shot_density, no_target} !== {7'd127, 4'd15, 4'd15, 6'd0, 1'b1}) begin
      bad++;
      $display("FAIL allfired_result: got pos=%0d r=%0d c=%0d d=%0d nt=%b want 127 15 15 0 1",
               shot_pos, shot_row, shot_col, shot_density, no_target);
    end
    handshake();
  endtask

  task automatic test_no_ships;
    tick();
    accept('0, 5'b00000);
    total++;
    if ({eng_start, shot_valid} !== 2'b01) begin
      bad++; $display("FAIL noships_immediate: got start=%b v=%b want start=0 v=1", eng_start, shot_valid);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({shot_valid, shot_pos, shot_row, shot_col, shot_density, no_target, eng_start}
          !== {1'b1, 7'd127, 4'd15, 4'd15, 6'd0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL noships_hold[%0d]: got v=%b pos=%0d r=%0d c=%0d d=%0d nt=%b st=%b want 1 127 15 15 0 1 0",
                 i, shot_valid, shot_pos, shot_row, shot_col, shot_density, no_target, eng_start);
      end
      tick();
    end
    handshake();
    total++;
    if ({shot_valid, shot_pos, no_target} !== {1'b0, 7'd127, 1'b1}) begin
      bad++; $display("FAIL noships_drop: got v=%b pos=%0d nt=%b want 0 127 1", shot_valid, shot_pos, no_target);
    end
  endtask

  task automatic test_timeout_and_abort;
    bit ok;
    bit seen;
    for (int i = 0; i < CELLS; i++) set_d(i, 5);
    tick();
    accept(100'h7, 5'b11111);
    tick();
    for (int i = 0; i < 1000; i++) tick();
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL tmo_early: got %b want 0", timeout_err);
    end
    wait_valid(300, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL tmo_no_shot: got no shot_valid want valid");
    end
    total++;
    if ({timeout_err, shot_pos, shot_row, shot_col, shot_density, no_target}
        !== {1'b1, 7'd3, 4'd0, 4'd3, 6'd0, 1'b0}) begin
      bad++;
      $display("FAIL tmo_fallback: got te=%b pos=%0d r=%0d c=%0d d=%0d nt=%b want 1 3 0 3 0 0",
               timeout_err, shot_pos, shot_row, shot_col, shot_density, no_target);
    end
    handshake();
    // Second request, reset in the middle of the scan.
    fill_mod(16);
    tick();
    accept('0, 5'b00011);
    done_at5();
    for (int i = 0; i < 20; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, eng_start, shot_valid, shot_pos, shot_row, shot_col, shot_density, no_target, timeout_err}
        !== {1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_outputs: got rdy=%b st=%b v=%b pos=%0d d=%0d nt=%b te=%b want rdy=1 others 0",
               req_ready, eng_start, shot_valid, shot_pos, shot_density, no_target, timeout_err);
    end
    total++;
    if ({eng_fired, eng_ships} !== '0) begin
      bad++; $display("FAIL abort_latch: got ships=%b want 0", eng_ships);
    end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (shot_valid || eng_start) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL abort_quiet: got activity=%b want 0", seen);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    fired      = '0;
    ships      = '0;
    eng_done   = 1'b0;
    density    = '0;
    shot_ready = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_peak();
    test_back_to_back_tie();
    test_fired_skip();
    test_all_fired();
    test_no_ships();
    test_timeout_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
